// File: rtl/sccb_master_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sccb_master_fifo
// Brief    : FIFO-fed SCCB master executing START/WRITE/READ/READ_ACK/STOP
//            commands back-to-back on an open-drain bus. Optional macro
//            SCCB_STRETCH_EN makes scl open-drain and honours clock stretching.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_master_fifo #(
    parameter int CLK_DIV    = 250,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       rst,
`ifdef SCCB_STRETCH_EN
    input  logic       scl_in,
`endif
    input  logic       in_flag,
    input  logic [3:0] in_cmd,
    input  logic [7:0] in_dat,
    output logic       cmd_full,
    inout  wire        sdl,
`ifdef SCCB_STRETCH_EN
    output wire        scl,
`else
    output logic       scl,
`endif
    output logic       sccb_e,
    output logic [7:0] out_dat,
    output logic       out_flag,
    output logic       ack_err,
    output logic       busy
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_QW = $clog2(CLK_DIV);
    localparam logic [c_QW-1:0] c_QLAST = c_QW'(CLK_DIV - 1);
    localparam logic [c_QW-1:0] c_QPRE  = c_QW'(CLK_DIV - 2);
    localparam logic [c_AW:0]   c_FULL  = (c_AW+1)'(FIFO_DEPTH);

    localparam logic [3:0] c_CMD_START    = 4'b0001;
    localparam logic [3:0] c_CMD_WRITE    = 4'b0010;
    localparam logic [3:0] c_CMD_READ     = 4'b0011;
    localparam logic [3:0] c_CMD_READ_ACK = 4'b0100;
    localparam logic [3:0] c_CMD_STOP     = 4'b0110;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t r_state, w_state_nx;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [11:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr, r_rptr;
    logic [c_AW:0]   r_count;
    logic            r_flag_d;
    logic            w_full, w_empty, w_push, w_pop;
    logic [11:0]     w_head;

    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);
    // Full is taken from the registered count, so a push racing a pop on a full FIFO is lost.
    assign w_push   = in_flag && !r_flag_d && !w_full;
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    assign w_head   = r_mem[r_rptr];
    assign cmd_full = w_full;
    assign busy     = !w_empty || (r_state != S_IDLE);

    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wptr] <= {in_cmd, in_dat};
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_flag_d <= 1'b0;
        end else begin
            r_flag_d <= in_flag;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bit engine
    // ------------------------------------------------------------------
    logic [c_QW-1:0] r_qcnt;
    logic [1:0]      r_phase;
    logic [3:0]      r_bit;
    logic [7:0]      r_tx, r_rx;
    logic            r_ack_mode, r_scl, r_sda_oe, r_sccb_e;
    logic            w_scl, w_sda_oe, w_hold, w_qwrap, w_slot_end, w_sample;

    assign w_qwrap    = (r_qcnt == c_QLAST);
    assign w_slot_end = w_qwrap && (r_phase == 2'd3);
    assign w_sample   = w_qwrap && (r_phase == 2'd2);

`ifdef SCCB_STRETCH_EN
    logic [1:0] r_scl_sync;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) r_scl_sync <= 2'b11;
        else      r_scl_sync <= {r_scl_sync[0], scl_in};
    end

    // A released-high phase waits at count 0 until the slave lets SCL rise.
    assign w_hold = (r_state != S_IDLE) && w_scl && (r_qcnt == '0) && !r_scl_sync[1];
    assign scl    = w_scl ? 1'bz : 1'b0;
`else
    assign w_hold = 1'b0;
    assign scl    = w_scl;
`endif

    assign sdl    = w_sda_oe ? 1'b0 : 1'bz;
    assign sccb_e = r_sccb_e;

    always_comb begin
        w_scl    = r_scl;
        w_sda_oe = r_sda_oe;
        case (r_state)
            S_START: begin
                case (r_phase)
                    2'd0: w_sda_oe = 1'b0;
                    2'd1: begin w_scl = 1'b1; w_sda_oe = 1'b0; end
                    2'd2: begin w_scl = 1'b1; w_sda_oe = 1'b1; end
                    default: begin w_scl = 1'b0; w_sda_oe = 1'b1; end
                endcase
            end
            S_WRITE: begin
                w_scl    = r_phase[1];
                w_sda_oe = (r_bit == 4'd8) ? 1'b0 : !r_tx[7];
            end
            S_READ: begin
                w_scl    = r_phase[1];
                w_sda_oe = (r_bit == 4'd8) ? r_ack_mode : 1'b0;
            end
            S_STOP: begin
                w_scl    = (r_phase != 2'd0);
                w_sda_oe = !r_phase[1];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    // Data/STOP commands outside an open transaction are dropped here.
                    case (w_head[11:8])
                        c_CMD_START:                w_state_nx = S_START;
                        c_CMD_WRITE:                if (!r_sccb_e) w_state_nx = S_WRITE;
                        c_CMD_READ, c_CMD_READ_ACK: if (!r_sccb_e) w_state_nx = S_READ;
                        c_CMD_STOP:                 if (!r_sccb_e) w_state_nx = S_STOP;
                        default:                    w_state_nx = S_IDLE;
                    endcase
                end
            end
            S_START, S_STOP: if (w_slot_end) w_state_nx = S_IDLE;
            S_WRITE, S_READ: if (w_slot_end && (r_bit == 4'd8)) w_state_nx = S_IDLE;
            default:         w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nx;
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_qcnt     <= '0;
            r_phase    <= 2'd0;
            r_bit      <= 4'd0;
            r_tx       <= 8'd0;
            r_rx       <= 8'd0;
            r_ack_mode <= 1'b0;
            r_scl      <= 1'b1;
            r_sda_oe   <= 1'b0;
            r_sccb_e   <= 1'b1;
            ack_err    <= 1'b0;
            out_dat    <= 8'd0;
            out_flag   <= 1'b0;
        end else begin
            r_scl    <= w_scl;
            r_sda_oe <= w_sda_oe;
            out_flag <= 1'b0;
            if (w_pop) begin
                r_tx       <= w_head[7:0];
                r_ack_mode <= (w_head[11:8] == c_CMD_READ_ACK);
                r_qcnt     <= '0;
                r_phase    <= 2'd0;
                r_bit      <= 4'd0;
                if (w_head[11:8] == c_CMD_START) begin
                    r_sccb_e <= 1'b0;
                    ack_err  <= 1'b0;
                end
            end else if (r_state != S_IDLE && !w_hold) begin
                if (w_qwrap) begin
                    r_qcnt  <= '0;
                    r_phase <= r_phase + 2'd1;
                    if (r_phase == 2'd3) begin
                        r_bit <= r_bit + 4'd1;
                        r_tx  <= {r_tx[6:0], 1'b0};
                    end
                end else begin
                    r_qcnt <= r_qcnt + 1'b1;
                end
                if (w_sample && r_state == S_WRITE && r_bit == 4'd8 && sdl)
                    ack_err <= 1'b1;
                if (w_sample && r_state == S_READ && r_bit != 4'd8)
                    r_rx <= {r_rx[6:0], sdl};
                // Register one cycle early so the pulse occupies the slot's last cycle.
                if (r_state == S_READ && r_bit == 4'd8 && r_phase == 2'd3 && r_qcnt == c_QPRE) begin
                    out_dat  <= r_rx;
                    out_flag <= 1'b1;
                end
                if (r_state == S_STOP && w_slot_end)
                    r_sccb_e <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sccb_master_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_master_fifo
// Brief    : Scoreboard bench for sccb_master_fifo with an SCCB slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_master_fifo;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;

    localparam logic [1:0] K_START = 2'd1;
    localparam logic [1:0] K_STOP  = 2'd2;
    localparam logic [1:0] K_FRAME = 2'd3;

    localparam logic [1:0] M_NONE  = 2'd0;
    localparam logic [1:0] M_WACK  = 2'd1;
    localparam logic [1:0] M_WNACK = 2'd2;
    localparam logic [1:0] M_READ  = 2'd3;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       in_flag;
    logic [3:0] in_cmd;
    logic [7:0] in_dat;
    logic       cmd_full, scl, sccb_e, out_flag, ack_err, busy;
    logic [7:0] out_dat;
    wire        sdl;
    logic       s_drv = 1'b0;

    int errs = 0;
    int chks = 0;
    int mon_nb = 0;

    logic [10:0] bus_q[$];
    logic [7:0]  rd_q[$];
    logic [9:0]  slave_q[$];

    pullup (sdl);
    assign sdl = s_drv ? 1'b0 : 1'bz;

    always #5 sys_clk = ~sys_clk;

    sccb_master_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .in_flag (in_flag),
        .in_cmd  (in_cmd),
        .in_dat  (in_dat),
        .cmd_full(cmd_full),
        .sdl     (sdl),
        .scl     (scl),
        .sccb_e  (sccb_e),
        .out_dat (out_dat),
        .out_flag(out_flag),
        .ack_err (ack_err),
        .busy    (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_event(input logic [1:0] kind, input logic [8:0] bits);
        if (bus_q.size() == 0) begin
            chks++;
            errs++;
            $display("FAIL bus_unexpected actual=%0h required=none at %0t", {kind, bits}, $time);
        end else begin
            chk("bus_event", 32'({kind, bits}), 32'(bus_q.pop_front()));
        end
    endtask

    // Bus monitor, read-byte monitor and slave model, all sampled on the falling clock edge
    initial begin : mon
        logic pscl, psdl, pflag;
        logic [8:0] sh;
        int hc;
        logic [9:0] act;
        logic act_v;
        pscl = 1'b1; psdl = 1'b1; pflag = 1'b0; sh = '0; hc = 0; act = '0; act_v = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!rst) begin
                mon_nb = 0; pflag = 1'b0; s_drv = 1'b0; act_v = 1'b0;
            end else begin
                if (pscl && scl && psdl && !sdl) begin
                    bus_event(K_START, 9'd0);
                    mon_nb = 0; s_drv = 1'b0; act_v = 1'b0;
                end else if (pscl && scl && !psdl && sdl) begin
                    bus_event(K_STOP, 9'd0);
                    mon_nb = 0; s_drv = 1'b0; act_v = 1'b0;
                end else if (!pscl && scl) begin
                    sh = {sh[7:0], sdl};
                    mon_nb++;
                    hc = 1;
                    if (mon_nb == 9) begin
                        bus_event(K_FRAME, sh);
                        chk("sccb_e_in_frame", 32'(sccb_e), 32'd0);
                        mon_nb = 0;
                    end
                end else if (pscl && !scl) begin
                    if (mon_nb >= 1 && mon_nb <= 8)
                        chk("scl_high_width", 32'(hc), 32'(2 * CLK_DIV));
                    if (mon_nb == 0) begin
                        act_v = (slave_q.size() > 0);
                        if (act_v) act = slave_q.pop_front();
                    end
                    s_drv = act_v && (((act[9:8] == M_READ) && mon_nb < 8 && !act[7 - mon_nb]) ||
                                      ((act[9:8] == M_WACK) && mon_nb == 8));
                end else if (scl) begin
                    hc++;
                end

                if (pflag) begin
                    chk("out_flag_pulse", 32'(out_flag), 32'd0);
                end else if (out_flag) begin
                    if (rd_q.size() == 0) begin
                        chks++;
                        errs++;
                        $display("FAIL read_unexpected actual=%0h required=none", out_dat);
                    end else begin
                        chk("read_byte", 32'(out_dat), 32'(rd_q.pop_front()));
                    end
                end
                pflag = out_flag;
            end
            pscl = scl;
            psdl = sdl;
        end
    end

    task automatic issue(input logic [3:0] c, input logic [7:0] d);
        @(posedge sys_clk); #1;
        in_cmd = c; in_dat = d; in_flag = 1'b1;
        @(posedge sys_clk); #1;
        in_flag = 1'b0;
    endtask

    task automatic cmd_start();
        bus_q.push_back({K_START, 9'd0});
        issue(4'b0001, 8'h00);
    endtask

    task automatic cmd_write(input logic [7:0] d, input logic slave_ack);
        slave_q.push_back({slave_ack ? M_WACK : M_WNACK, d});
        bus_q.push_back({K_FRAME, d, !slave_ack});
        issue(4'b0010, d);
    endtask

    task automatic cmd_read(input logic [7:0] d, input logic master_ack);
        slave_q.push_back({M_READ, d});
        bus_q.push_back({K_FRAME, d, !master_ack});
        rd_q.push_back(d);
        issue(master_ack ? 4'b0100 : 4'b0011, 8'h00);
    endtask

    task automatic cmd_stop();
        slave_q.push_back({M_NONE, 8'h00});
        bus_q.push_back({K_STOP, 9'd0});
        issue(4'b0110, 8'h00);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 4000) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin : stim
        int n;
        rst = 1'b0; in_flag = 1'b0; in_cmd = 4'd0; in_dat = 8'd0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_scl", 32'(scl), 32'd1);
        chk("reset_sdl", 32'(sdl), 32'd1);
        chk("reset_sccb_e", 32'(sccb_e), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ack_err", 32'(ack_err), 32'd0);
        chk("reset_out_flag", 32'(out_flag), 32'd0);
        chk("reset_cmd_full", 32'(cmd_full), 32'd0);
        chk("reset_out_dat", 32'(out_dat), 32'd0);
        @(negedge sys_clk);
        rst = 1'b1;
        repeat (2) @(posedge sys_clk);

        // Write 0x91 with slave ACK
        cmd_start();
        cmd_write(8'h91, 1'b1);
        cmd_stop();
        wait_idle("idle_write91");
        chk("ack_err_after_ack", 32'(ack_err), 32'd0);
        chk("sccb_e_after_stop", 32'(sccb_e), 32'd1);

        // Write 0x42 without ACK, then a new START clears the error
        cmd_start();
        cmd_write(8'h42, 1'b0);
        cmd_stop();
        wait_idle("idle_write42");
        chk("ack_err_nack", 32'(ack_err), 32'd1);
        repeat (5) @(posedge sys_clk);
        #1;
        chk("ack_err_sticky", 32'(ack_err), 32'd1);
        cmd_start();
        n = 0;
        while (sccb_e && n < 100) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("start_q0_sccb_e", 32'(sccb_e), 32'd0);
        chk("ack_err_cleared", 32'(ack_err), 32'd0);
        cmd_stop();
        wait_idle("idle_restart");

        // Discarded commands: invalid code and WRITE outside a transaction
        issue(4'b0000, 8'hFF);
        issue(4'b0010, 8'h55);
        wait_idle("idle_discard");
        chk("discard_sccb_e", 32'(sccb_e), 32'd1);

        // Reads: NACK then ACK
        cmd_start();
        cmd_read(8'h5A, 1'b0);
        cmd_read(8'hC3, 1'b1);
        cmd_stop();
        wait_idle("idle_reads");

        // FIFO fill: first popped, four stored, sixth dropped
        cmd_start();
        cmd_write(8'hA5, 1'b1);
        cmd_read(8'h3C, 1'b0);
        cmd_write(8'h0F, 1'b1);
        cmd_stop();
        chk("fifo_full", 32'(cmd_full), 32'd1);
        issue(4'b0010, 8'h77);
        chk("fifo_full_after_drop", 32'(cmd_full), 32'd1);
        wait_idle("idle_fifo");

        // Reset during bit 4 of a WRITE
        cmd_start();
        cmd_write(8'hF0, 1'b1);
        cmd_stop();
        n = 0;
        while (!(mon_nb == 4 && !scl && !sccb_e) && n < 2000) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("reached_bit4", 32'(mon_nb), 32'd4);
        rst = 1'b0;
        #1;
        chk("abort_scl", 32'(scl), 32'd1);
        chk("abort_sdl", 32'(sdl), 32'd1);
        chk("abort_sccb_e", 32'(sccb_e), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cmd_full", 32'(cmd_full), 32'd0);
        bus_q.delete();
        slave_q.delete();
        repeat (3) @(posedge sys_clk);
        #1;
        rst = 1'b1;
        repeat (60) @(posedge sys_clk);
        #1;
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_sccb_e", 32'(sccb_e), 32'd1);

        repeat (10) @(posedge sys_clk);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("slave_q_drained", 32'(slave_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
`default_nettype wire
